vector_alu_controller: RTL and testbench
========================================

VECTOR_ALU_CONTROLLER -- requirements
Module: vector_alu_controller

Interface
REQ-001 SHALL have parameter BITS, default 8, element width in bits.
REQ-002 SHALL have parameter REG_AW, default 3, vector register-file address width.
REQ-003 SHALL have parameter CNT_W, default 16, completed-operation counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid  input  1  command offered.
REQ-007 SHALL have port cmd_ready  output  1  controller accepts command this cycle.
REQ-008 SHALL have port cmd_op  input  3  ALU op code (000 add, 001 sub, 010 mult, 011 cmp, 100 and, 101 or, 110 xor, 111 not).
REQ-009 SHALL have port cmd_clr  input  1  clear-only command: zero ALU output register, no writeback.
REQ-010 SHALL have port cmd_scalar_sel  input  1  use scalar as B operand.
REQ-011 SHALL have port cmd_scalar  input  BITS  scalar operand.
REQ-012 SHALL have port cmd_src_a, cmd_src_b, cmd_dst  input  REG_AW each  register addresses.
REQ-013 SHALL have port abort  input  1  cancel in-flight command.
REQ-014 SHALL have port rf_re  output  1  register-file read strobe (data valid next cycle).
REQ-015 SHALL have port rf_raddr_a, rf_raddr_b  output  REG_AW each  read addresses.
REQ-016 SHALL have port rf_we  output  1  register-file write strobe, writes ALU output S.
REQ-017 SHALL have port rf_waddr  output  REG_AW  write address.
REQ-018 SHALL have port alu_op_sel  output  3  to ALU op select.
REQ-019 SHALL have port alu_scalar_sel  output  1  to ALU scalar select.
REQ-020 SHALL have port alu_scalar  output  BITS  to ALU scalar input.
REQ-021 SHALL have port alu_set  output  1  ALU output register synchronous clear.
REQ-022 SHALL have port alu_en  output  1  ALU output register load enable.
REQ-023 SHALL have port done  output  1  one-cycle pulse on command completion.
REQ-024 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-025 SHALL have port op_count  output  CNT_W  count of completed (non-aborted) commands.

Function
REQ-026 SHALL implement FSM states IDLE, READ, EXEC, WB, CLR.
REQ-027 SHALL drive cmd_ready high only in IDLE; handshake occurs when cmd_valid and cmd_ready are both high.
REQ-028 SHALL capture all cmd_* fields at handshake into internal registers; later input changes have no effect on the in-flight command.
REQ-029 SHALL transition IDLE->READ on handshake with cmd_clr=0; IDLE->CLR on handshake with cmd_clr=1.
REQ-030 SHALL, in READ, assert rf_re with rf_raddr_a/b equal to captured sources; READ->EXEC unconditionally.
REQ-031 SHALL, in EXEC, assert alu_en for exactly one cycle; EXEC->WB.
REQ-032 SHALL, in WB, assert rf_we with rf_waddr equal to captured dst, assert done, increment op_count; WB->IDLE.
REQ-033 SHALL, in CLR, assert alu_set for one cycle, assert done, increment op_count; CLR->IDLE.
REQ-034 SHALL hold alu_op_sel, alu_scalar_sel, alu_scalar at captured values from READ through WB.
REQ-035 SHALL give arithmetic latency: handshake at cycle 0 -> rf_re cycle 1, alu_en cycle 2, rf_we and done cycle 3, cmd_ready cycle 4.
REQ-036 SHALL allow cmd_src_a, cmd_src_b, cmd_dst to alias; commands are strictly serial, so no hazard exists.
REQ-037 SHALL, on abort high in READ, EXEC or CLR, return to IDLE next cycle with no rf_we, no alu_set, no done, and no op_count increment.
REQ-038 SHALL ignore abort in IDLE and in WB; the WB cycle always completes.
REQ-039 SHALL wrap op_count from 2^CNT_W-1 to 0.
REQ-040 SHALL keep rf_re, rf_we, alu_en, alu_set and done low outside their designated states.

Reset
REQ-041 SHALL, on rst_n low, asynchronously force state IDLE, all strobes and done low, busy 0, op_count 0, and captured fields and alu_* outputs 0; cmd_ready rises in the first cycle after release.
REQ-042 SHALL, on reset mid-command, discard that command with no writeback.

Verification
REQ-043 Add: op=000, src_a=1, src_b=2, dst=3 handshake at cycle 0 -> rf_re at cycle 1, alu_en at cycle 2, rf_we and waddr=3 and done at cycle 3, op_count=1.
REQ-044 Scalar mult: op=010, scalar_sel=1, scalar=8'h05 -> alu_scalar_sel=1, alu_scalar=05 held from cycle 1 to cycle 3; cmd_* changed at cycle 1 has no effect.
REQ-045 Clear: cmd_clr=1 -> alu_set for one cycle at cycle 1 with done; rf_re and rf_we never asserted.
REQ-046 Abort in EXEC -> IDLE next cycle; no rf_we or done; op_count unchanged; back-to-back command accepted immediately after.
REQ-047 rst_n low during WB -> rf_we low immediately, op_count=0; preload op_count=16'hFFFF then one completion -> 0.

Source files
------------

// File: rtl/vector_alu_controller.sv
// rtl/vector_alu_controller.sv - sequencing controller for a vector ALU and its register file
//
// Accepts one command at a time over a valid/ready handshake and walks it
// through READ -> EXEC -> WB (arithmetic) or CLR (clear-only).
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_op, cmd_clr, cmd_scalar_sel,
//   cmd_scalar, cmd_src_a/b, cmd_dst command fields, captured at handshake
//   abort                            cancel in-flight command (READ/EXEC/CLR)
//   rf_re, rf_raddr_a/b              register-file read port
//   rf_we, rf_waddr                  register-file write port
//   alu_op_sel, alu_scalar_sel,
//   alu_scalar, alu_set, alu_en      ALU controls
//   done, busy, op_count             status
module vector_alu_controller #(
    parameter int BITS   = 8,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic              cmd_clr,
    input  logic              cmd_scalar_sel,
    input  logic [BITS-1:0]   cmd_scalar,
    input  logic [REG_AW-1:0] cmd_src_a,
    input  logic [REG_AW-1:0] cmd_src_b,
    input  logic [REG_AW-1:0] cmd_dst,
    input  logic              abort,
    output logic              rf_re,
    output logic [REG_AW-1:0] rf_raddr_a,
    output logic [REG_AW-1:0] rf_raddr_b,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [2:0]        alu_op_sel,
    output logic              alu_scalar_sel,
    output logic [BITS-1:0]   alu_scalar,
    output logic              alu_set,
    output logic              alu_en,
    output logic              done,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_CLR  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic               scalar_sel_q, scalar_sel_d;
    logic [BITS-1:0]    scalar_q, scalar_d;
    logic [REG_AW-1:0]  src_a_q, src_a_d;
    logic [REG_AW-1:0]  src_b_q, src_b_d;
    logic [REG_AW-1:0]  dst_q, dst_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            scalar_sel_q <= 1'b0;
            scalar_q     <= '0;
            src_a_q      <= '0;
            src_b_q      <= '0;
            dst_q        <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            scalar_sel_q <= scalar_sel_d;
            scalar_q     <= scalar_d;
            src_a_q      <= src_a_d;
            src_b_q      <= src_b_d;
            dst_q        <= dst_d;
            count_q      <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        scalar_sel_d = scalar_sel_q;
        scalar_d     = scalar_q;
        src_a_d      = src_a_q;
        src_b_d      = src_b_q;
        dst_d        = dst_q;
        count_d      = count_q;
        cmd_ready    = 1'b0;
        rf_re        = 1'b0;
        rf_we        = 1'b0;
        alu_en       = 1'b0;
        alu_set      = 1'b0;
        done         = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d         = cmd_op;
                    scalar_sel_d = cmd_scalar_sel;
                    scalar_d     = cmd_scalar;
                    src_a_d      = cmd_src_a;
                    src_b_d      = cmd_src_b;
                    dst_d        = cmd_dst;
                    state_d      = cmd_clr ? S_CLR : S_READ;
                end
            end
            S_READ: begin
                rf_re   = 1'b1;
                state_d = abort ? S_IDLE : S_EXEC;
            end
            S_EXEC: begin
                // An aborted command must not disturb the ALU output register.
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    alu_en  = 1'b1;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                // Abort is deliberately ignored here: writeback always completes.
                rf_we   = 1'b1;
                done    = 1'b1;
                count_d = count_q + 1'b1;
                state_d = S_IDLE;
            end
            S_CLR: begin
                if (!abort) begin
                    alu_set = 1'b1;
                    done    = 1'b1;
                    count_d = count_q + 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rf_raddr_a     = src_a_q;
    assign rf_raddr_b     = src_b_q;
    assign rf_waddr       = dst_q;
    assign alu_op_sel     = op_q;
    assign alu_scalar_sel = scalar_sel_q;
    assign alu_scalar     = scalar_q;
    assign busy           = (state_q != S_IDLE);
    assign op_count       = count_q;

endmodule

// File: tb/tb_vector_alu_controller.sv
// tb/tb_vector_alu_controller.sv - self-checking bench for vector_alu_controller
module tb_vector_alu_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_clr, cmd_scalar_sel, abort;
    logic [2:0] cmd_op, cmd_src_a, cmd_src_b, cmd_dst;
    logic [7:0] cmd_scalar;

    logic        cmd_ready, rf_re, rf_we, alu_scalar_sel, alu_set, alu_en, done, busy;
    logic [2:0]  rf_raddr_a, rf_raddr_b, rf_waddr, alu_op_sel;
    logic [7:0]  alu_scalar;
    logic [15:0] op_count;

    logic        s_cmd_ready, s_rf_re, s_rf_we, s_alu_scalar_sel, s_alu_set, s_alu_en, s_done, s_busy;
    logic [2:0]  s_rf_raddr_a, s_rf_raddr_b, s_rf_waddr, s_alu_op_sel;
    logic [7:0]  s_alu_scalar;
    logic [1:0]  s_op_count;

    always #5 clk = ~clk;

    vector_alu_controller u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_clr(cmd_clr), .cmd_scalar_sel(cmd_scalar_sel),
        .cmd_scalar(cmd_scalar), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
        .cmd_dst(cmd_dst), .abort(abort), .rf_re(rf_re), .rf_raddr_a(rf_raddr_a),
        .rf_raddr_b(rf_raddr_b), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .alu_op_sel(alu_op_sel), .alu_scalar_sel(alu_scalar_sel), .alu_scalar(alu_scalar),
        .alu_set(alu_set), .alu_en(alu_en), .done(done), .busy(busy), .op_count(op_count)
    );

    // Narrow counter copy: exercises op_count wrap-around in a few commands.
    vector_alu_controller #(.CNT_W(2)) u_small (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
        .cmd_op(cmd_op), .cmd_clr(cmd_clr), .cmd_scalar_sel(cmd_scalar_sel),
        .cmd_scalar(cmd_scalar), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
        .cmd_dst(cmd_dst), .abort(abort), .rf_re(s_rf_re), .rf_raddr_a(s_rf_raddr_a),
        .rf_raddr_b(s_rf_raddr_b), .rf_we(s_rf_we), .rf_waddr(s_rf_waddr),
        .alu_op_sel(s_alu_op_sel), .alu_scalar_sel(s_alu_scalar_sel), .alu_scalar(s_alu_scalar),
        .alu_set(s_alu_set), .alu_en(s_alu_en), .done(s_done), .busy(s_busy), .op_count(s_op_count)
    );

    typedef struct {
        logic [2:0] op;
        logic       clr;
        logic       ssel;
        logic [7:0] scalar;
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] d;
        logic       exp_re;
        logic       exp_we;
        logic       exp_set;
    } vec_t;

    typedef struct {
        logic        we;
        logic [2:0]  waddr;
        logic        set;
        logic [15:0] cnt;
    } sb_t;

    vec_t  tbl [8];
    sb_t   sb_q [$];
    int    n_tests = 0;
    int    n_fail  = 0;
    logic [15:0] exp_cnt = '0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Completion monitor: every done pops one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no completion at %0t", $time);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    chk("sb_rf_we", rf_we, e.we);
                    if (e.we) chk("sb_waddr", rf_waddr, e.waddr);
                    chk("sb_alu_set", alu_set, e.set);
                    chk("sb_op_count", op_count, e.cnt);
                end
            end else if (rf_we || alu_set) begin
                n_tests++;
                n_fail++;
                $display("FAIL strobe_without_done: got we=%0b set=%0b with done=0 at %0t", rf_we, alu_set, $time);
            end
        end
    end

    // abort_at: 0 = none, else the cycle after handshake in which abort is held high.
    task automatic run_cmd(input vec_t v, input int abort_at);
        bit completes;
        int len;
        completes = (abort_at == 0) || (!v.clr && abort_at == 3);
        len = v.clr ? 1 : 3;
        if (completes) begin
            sb_q.push_back('{we: v.exp_we, waddr: v.d, set: v.exp_set, cnt: exp_cnt});
            exp_cnt++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = v.op; cmd_clr = v.clr; cmd_scalar_sel = v.ssel;
        cmd_scalar = v.scalar; cmd_src_a = v.a; cmd_src_b = v.b; cmd_dst = v.d;
        @(negedge clk);
        chk("hs_ready", cmd_ready, 1);
        for (int c = 1; c <= len; c++) begin
            @(posedge clk); #1;
            // Scramble the command bus: the in-flight command must not see it.
            cmd_valid = 1'b0; cmd_op = ~v.op; cmd_clr = ~v.clr; cmd_scalar_sel = ~v.ssel;
            cmd_scalar = ~v.scalar; cmd_src_a = ~v.a; cmd_src_b = ~v.b; cmd_dst = ~v.d;
            abort = (c == abort_at);
            @(negedge clk);
            chk("busy", busy, 1);
            chk("cmd_ready_busy", cmd_ready, 0);
            chk("rf_re", rf_re, (v.exp_re && c == 1) ? 1 : 0);
            chk("alu_en", alu_en, (!v.clr && c == 2 && abort_at != 2) ? 1 : 0);
            chk("alu_set", alu_set, (v.clr && c == 1 && abort_at != 1) ? 1 : 0);
            if (!v.clr) begin
                chk("alu_op_sel", alu_op_sel, v.op);
                chk("alu_scalar_sel", alu_scalar_sel, v.ssel);
                chk("alu_scalar", alu_scalar, v.scalar);
                if (c == 1) begin
                    chk("raddr_a", rf_raddr_a, v.a);
                    chk("raddr_b", rf_raddr_b, v.b);
                end
            end
            if (abort_at == c && !(c == 3 && !v.clr)) break;
        end
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("idle_ready", cmd_ready, 1);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        tbl[0] = '{3'd0, 1'b0, 1'b0, 8'h00, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{3'd2, 1'b0, 1'b1, 8'h05, 3'd4, 3'd0, 3'd6, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{3'd0, 1'b1, 1'b0, 8'h00, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{3'd1, 1'b0, 1'b0, 8'h00, 3'd5, 3'd5, 3'd5, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{3'd3, 1'b0, 1'b0, 8'h00, 3'd7, 3'd0, 3'd7, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{3'd6, 1'b0, 1'b1, 8'hFF, 3'd2, 3'd3, 3'd0, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{3'd7, 1'b0, 1'b0, 8'h00, 3'd6, 3'd6, 3'd1, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{3'd5, 1'b0, 1'b0, 8'hA5, 3'd0, 3'd1, 3'd2, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_clr = 1'b0; cmd_scalar_sel = 1'b0;
        cmd_scalar = '0; cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0; abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_done", done, 0);
        chk("rst_alu_scalar", alu_scalar, 0);
        chk("rst_alu_op_sel", alu_op_sel, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);

        for (int i = 0; i < 8; i++) run_cmd(tbl[i], 0);
        chk("count_after_table", op_count, exp_cnt);
        chk("small_count_after_table", s_op_count, int'(exp_cnt[1:0]));

        run_cmd(tbl[0], 2);     // abort in EXEC
        chk("count_after_exec_abort", op_count, exp_cnt);
        run_cmd(tbl[3], 0);     // next command accepted right away
        run_cmd(tbl[4], 1);     // abort in READ
        run_cmd(tbl[2], 1);     // abort in CLR
        run_cmd(tbl[5], 3);     // abort in WB is ignored
        chk("count_after_aborts", op_count, exp_cnt);

        // Reset asserted during WB.
        sb_q.push_back('{we: 1'b1, waddr: tbl[0].d, set: 1'b0, cnt: exp_cnt});
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = tbl[0].op; cmd_clr = 1'b0; cmd_scalar_sel = 1'b0;
        cmd_src_a = tbl[0].a; cmd_src_b = tbl[0].b; cmd_dst = tbl[0].d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("wb_before_reset", rf_we, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_wb_rf_we", rf_we, 0);
        chk("reset_wb_done", done, 0);
        chk("reset_wb_op_count", op_count, 0);
        chk("reset_wb_busy", busy, 0);
        chk("reset_wb_small_count", s_op_count, 0);
        exp_cnt = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_wb_ready", cmd_ready, 1);
        chk("reset_wb_no_writeback", rf_we, 0);

        // Wrap: four completions wrap the 2-bit counter to zero.
        for (int i = 0; i < 3; i++) run_cmd(tbl[2], 0);
        chk("small_count_3", s_op_count, 3);
        run_cmd(tbl[2], 0);
        chk("small_count_wrap", s_op_count, 0);
        chk("wide_count_4", op_count, 4);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
